// File: rtl/munoc_apb_to_axi4l_bridge_pkg.sv
// munoc_apb_to_axi4l_bridge_pkg
// Shared definitions for the APB -> AXI4-Lite bridge:
//   - bridge_state_e : 3-bit FSM state encoding
//   - resp_is_err()  : true for SLVERR / DECERR responses
//   - timer_width()  : response-timer counter width, never below 1
package munoc_apb_to_axi4l_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } bridge_state_e;

    // SLVERR (2'b10) and DECERR (2'b11) both report an error to APB.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == 2'b10) || (resp == 2'b11);
    endfunction

    function automatic int timer_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/munoc_apb_to_axi4l_bridge_response_timer.sv
// munoc_apb_to_axi4l_bridge_response_timer
// Counts cycles while enabled and flags expiry on the LIMIT-th enabled
// cycle. LIMIT = 0 disables the timer (expire tied low).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous counter clear (wins over enable)
//   enable   : count this cycle
//   expire   : high in the LIMIT-th consecutive enabled cycle
module munoc_apb_to_axi4l_bridge_response_timer
    import munoc_apb_to_axi4l_bridge_pkg::*;
#(
    parameter int LIMIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW       = timer_width(LIMIT);
    localparam logic [CW-1:0] LAST     = CW'(LIMIT - 1);
    localparam bit            TIMER_ON = (LIMIT != 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority, otherwise increment when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CW{1'b0}};
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count before increment equals LAST in the LIMIT-th waiting cycle.
    assign expire = TIMER_ON && enable && (cnt_q == LAST);

endmodule

// File: rtl/munoc_apb_to_axi4l_bridge.sv
// munoc_apb_to_axi4l_bridge
// Converts single APB transfers into AXI4-Lite transactions, one at a time.
// A response timer completes a hung transfer with SLVERR; the late response
// is then drained (orphan_b / orphan_r) before a new transfer is accepted.
// Ports:
//   clk, rstpp                       : clock, asynchronous active-high reset
//   spsel/spenable/spwrite/spaddr/
//   spwdata/spstrb                   : APB request
//   sprdata/spready/spslverr         : APB completion (registered)
//   x4law*, x4lw*, x4lb*             : AXI4-Lite write channels
//   x4lar*, x4lr*                    : AXI4-Lite read channels
module munoc_apb_to_axi4l_bridge
    import munoc_apb_to_axi4l_bridge_pkg::*;
#(
    parameter int BW_PLATFORM_ADDR = 32,
    parameter int BW_NODE_DATA     = 32,
    parameter int TIMEOUT_CYCLES   = 0
) (
    input  logic                        clk,
    input  logic                        rstpp,
    input  logic                        spsel,
    input  logic                        spenable,
    input  logic                        spwrite,
    input  logic [BW_PLATFORM_ADDR-1:0] spaddr,
    input  logic [BW_NODE_DATA-1:0]     spwdata,
    input  logic [BW_NODE_DATA/8-1:0]   spstrb,
    output logic [BW_NODE_DATA-1:0]     sprdata,
    output logic                        spready,
    output logic                        spslverr,
    output logic [BW_PLATFORM_ADDR-1:0] x4lawaddr,
    output logic                        x4lawvalid,
    input  logic                        x4lawready,
    output logic [BW_NODE_DATA-1:0]     x4lwdata,
    output logic [BW_NODE_DATA/8-1:0]   x4lwstrb,
    output logic                        x4lwvalid,
    input  logic                        x4lwready,
    input  logic [1:0]                  x4lbresp,
    input  logic                        x4lbvalid,
    output logic                        x4lbready,
    output logic [BW_PLATFORM_ADDR-1:0] x4laraddr,
    output logic                        x4larvalid,
    input  logic                        x4larready,
    input  logic [BW_NODE_DATA-1:0]     x4lrdata,
    input  logic [1:0]                  x4lrresp,
    input  logic                        x4lrvalid,
    output logic                        x4lrready
);

    localparam int SW = BW_NODE_DATA / 8;

    bridge_state_e               state_q,    state_d;
    logic [BW_PLATFORM_ADDR-1:0] addr_q,     addr_d;
    logic [BW_NODE_DATA-1:0]     wdata_q,    wdata_d;
    logic [SW-1:0]               strb_q,     strb_d;
    logic                        awvalid_q,  awvalid_d;
    logic                        wvalid_q,   wvalid_d;
    logic                        arvalid_q,  arvalid_d;
    logic                        bready_q,   bready_d;
    logic                        rready_q,   rready_d;
    logic                        aw_done_q,  aw_done_d;
    logic                        w_done_q,   w_done_d;
    logic [BW_NODE_DATA-1:0]     sprdata_q,  sprdata_d;
    logic                        spslverr_q, spslverr_d;
    logic                        spready_q,  spready_d;
    logic                        orphan_b_q, orphan_b_d;
    logic                        orphan_r_q, orphan_r_d;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic waiting, expire;

    assign aw_hs = awvalid_q & x4lawready;
    assign w_hs  = wvalid_q  & x4lwready;
    assign ar_hs = arvalid_q & x4larready;
    assign b_hs  = bready_q  & x4lbvalid;
    assign r_hs  = rready_q  & x4lrvalid;

    // The timer only runs while a response is awaited.
    assign waiting = (state_q == ST_WRESP) || (state_q == ST_RDATA);

    munoc_apb_to_axi4l_bridge_response_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rstpp),
        .clear  (!waiting),
        .enable (waiting),
        .expire (expire)
    );

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        sprdata_d  = sprdata_q;
        spslverr_d = spslverr_q;
        spready_d  = 1'b0;

        // A late response after a timeout is swallowed here; it never
        // reaches sprdata/spslverr.
        if (orphan_b_q && b_hs) begin
            orphan_b_d = 1'b0;
        end else begin
            orphan_b_d = orphan_b_q;
        end
        if (orphan_r_q && r_hs) begin
            orphan_r_d = 1'b0;
        end else begin
            orphan_r_d = orphan_r_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (spsel && spenable && !orphan_b_q && !orphan_r_q) begin
                    addr_d  = spaddr;
                    wdata_d = spwdata;
                    strb_d  = spstrb;
                    if (spwrite) begin
                        state_d   = ST_WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = ST_RADDR;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WADDR: begin
                // AW and W complete independently, in either order.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WRESP;
                end else begin
                    state_d = ST_WADDR;
                end
            end
            ST_WRESP: begin
                // A response on the expiry cycle still wins over the timeout.
                if (b_hs) begin
                    spslverr_d = resp_is_err(x4lbresp);
                    spready_d  = 1'b1;
                    state_d    = ST_DONE;
                end else if (expire) begin
                    spslverr_d = 1'b1;
                    sprdata_d  = {BW_NODE_DATA{1'b0}};
                    orphan_b_d = 1'b1;
                    spready_d  = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_WRESP;
                end
            end
            ST_RADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RDATA;
                end else begin
                    state_d = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (r_hs) begin
                    sprdata_d  = x4lrdata;
                    spslverr_d = resp_is_err(x4lrresp);
                    spready_d  = 1'b1;
                    state_d    = ST_DONE;
                end else if (expire) begin
                    spslverr_d = 1'b1;
                    sprdata_d  = {BW_NODE_DATA{1'b0}};
                    orphan_r_d = 1'b1;
                    spready_d  = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase

        // Ready is held in the wait state and for as long as an orphan is pending.
        bready_d = (state_d == ST_WRESP) || orphan_b_d;
        rready_d = (state_d == ST_RDATA) || orphan_r_d;
    end

    // All FSM state and registered outputs.
    always_ff @(posedge clk or posedge rstpp) begin
        if (rstpp) begin
            state_q    <= ST_IDLE;
            addr_q     <= {BW_PLATFORM_ADDR{1'b0}};
            wdata_q    <= {BW_NODE_DATA{1'b0}};
            strb_q     <= {SW{1'b0}};
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            sprdata_q  <= {BW_NODE_DATA{1'b0}};
            spslverr_q <= 1'b0;
            spready_q  <= 1'b0;
            orphan_b_q <= 1'b0;
            orphan_r_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            bready_q   <= bready_d;
            rready_q   <= rready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            sprdata_q  <= sprdata_d;
            spslverr_q <= spslverr_d;
            spready_q  <= spready_d;
            orphan_b_q <= orphan_b_d;
            orphan_r_q <= orphan_r_d;
        end
    end

    assign sprdata    = sprdata_q;
    assign spready    = spready_q;
    assign spslverr   = spslverr_q;
    assign x4lawaddr  = addr_q;
    assign x4lawvalid = awvalid_q;
    assign x4lwdata   = wdata_q;
    assign x4lwstrb   = strb_q;
    assign x4lwvalid  = wvalid_q;
    assign x4lbready  = bready_q;
    assign x4laraddr  = addr_q;
    assign x4larvalid = arvalid_q;
    assign x4lrready  = rready_q;

endmodule

// File: tb/tb_munoc_apb_to_axi4l_bridge.sv
// Self-checking bench for munoc_apb_to_axi4l_bridge (TIMEOUT_CYCLES = 8).
// A table of transfers drives an APB master and an AXI4-Lite slave model in
// parallel; expected completions go through a scoreboard queue.
module tb_munoc_apb_to_axi4l_bridge;

    localparam int TMO   = 8;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rstpp;
    logic        spsel, spenable, spwrite;
    logic [31:0] spaddr, spwdata;
    logic [3:0]  spstrb;
    logic [31:0] sprdata;
    logic        spready, spslverr;
    logic [31:0] x4lawaddr, x4lwdata, x4laraddr, x4lrdata;
    logic [3:0]  x4lwstrb;
    logic        x4lawvalid, x4lawready, x4lwvalid, x4lwready;
    logic [1:0]  x4lbresp, x4lrresp;
    logic        x4lbvalid, x4lbready, x4larvalid, x4larready, x4lrvalid, x4lrready;

    always #5 clk = ~clk;

    munoc_apb_to_axi4l_bridge #(
        .BW_PLATFORM_ADDR (32),
        .BW_NODE_DATA     (32),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .clk        (clk),
        .rstpp      (rstpp),
        .spsel      (spsel),
        .spenable   (spenable),
        .spwrite    (spwrite),
        .spaddr     (spaddr),
        .spwdata    (spwdata),
        .spstrb     (spstrb),
        .sprdata    (sprdata),
        .spready    (spready),
        .spslverr   (spslverr),
        .x4lawaddr  (x4lawaddr),
        .x4lawvalid (x4lawvalid),
        .x4lawready (x4lawready),
        .x4lwdata   (x4lwdata),
        .x4lwstrb   (x4lwstrb),
        .x4lwvalid  (x4lwvalid),
        .x4lwready  (x4lwready),
        .x4lbresp   (x4lbresp),
        .x4lbvalid  (x4lbvalid),
        .x4lbready  (x4lbready),
        .x4laraddr  (x4laraddr),
        .x4larvalid (x4larvalid),
        .x4larready (x4larready),
        .x4lrdata   (x4lrdata),
        .x4lrresp   (x4lrresp),
        .x4lrvalid  (x4lrvalid),
        .x4lrready  (x4lrready)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          a_dly;     // AW (write) or AR (read) ready delay
        int          w_dly;
        int          resp_dly;  // cycles in the wait state before B/R valid
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        exp_err;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        int          exp_lat;   // cycles from first spenable to spready, -1 = skip
    } vec_t;

    typedef struct {
        logic        err;
        logic        chk_rdata;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mkv(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input int a_dly, input int w_dly,
                                 input int resp_dly, input logic [1:0] resp, input logic [31:0] rdata,
                                 input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                                 input int exp_lat);
        vec_t v;
        v.write = wr;  v.addr = addr;  v.wdata = wdata;  v.strb = strb;
        v.a_dly = a_dly;  v.w_dly = w_dly;  v.resp_dly = resp_dly;
        v.resp = resp;  v.rdata = rdata;
        v.exp_err = exp_err;  v.chk_rdata = chk_rd;  v.exp_rdata = exp_rd;  v.exp_lat = exp_lat;
        return v;
    endfunction

    // APB setup + access phase; expectation goes onto the scoreboard.
    task automatic apb_begin(input vec_t v);
        exp_t e;
        e.err = v.exp_err;  e.chk_rdata = v.chk_rdata;  e.rdata = v.exp_rdata;  e.lat = v.exp_lat;
        sb_q.push_back(e);
        @(negedge clk);
        spsel = 1'b1;  spenable = 1'b0;  spwrite = v.write;
        spaddr = v.addr;  spwdata = v.wdata;  spstrb = v.strb;
        @(negedge clk);
        spenable = 1'b1;
    endtask

    // Wait (bounded) for spready, then pop and compare.
    task automatic apb_finish();
        int   lat = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (spready) seen = 1'b1;
        end
        e = sb_q.pop_front();
        chk("spready_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("spslverr", 64'(spslverr), 64'(e.err));
            if (e.chk_rdata) chk("sprdata", 64'(sprdata), 64'(e.rdata));
            if (e.lat >= 0) chk("latency", 64'(lat), 64'(e.lat));
        end
        spsel = 1'b0;  spenable = 1'b0;
        @(negedge clk);
        chk("spready_one_cycle", 64'(spready), 64'd0);
    endtask

    // AXI4-Lite write slave: delayed AW/W readies, then a delayed B.
    task automatic slave_write(input vec_t v);
        int n = 0, aw_cnt = 0, w_cnt = 0, c = 1;
        bit aw_got = 1'b0, w_got = 1'b0, first = 1'b1, done = 1'b0;
        while (!(aw_got && w_got) && n < 200) begin
            @(negedge clk);
            n++;
            x4lawready = 1'b0;  x4lwready = 1'b0;
            if (first && (x4lawvalid || x4lwvalid)) begin
                chk("aw_w_together", 64'({x4lawvalid, x4lwvalid}), 64'd3);
                chk("awaddr", 64'(x4lawaddr), 64'(v.addr));
                chk("wdata", 64'(x4lwdata), 64'(v.wdata));
                chk("wstrb", 64'(x4lwstrb), 64'(v.strb));
                first = 1'b0;
            end
            if (aw_got) chk("awvalid_drop", 64'(x4lawvalid), 64'd0);
            else if (aw_cnt > 0) chk("awvalid_hold", 64'(x4lawvalid), 64'd1);
            if (w_got) chk("wvalid_drop", 64'(x4lwvalid), 64'd0);
            else if (w_cnt > 0) chk("wvalid_hold", 64'(x4lwvalid), 64'd1);
            if (!aw_got && x4lawvalid) begin
                aw_cnt++;
                if (aw_cnt > v.a_dly) begin x4lawready = 1'b1; aw_got = 1'b1; end
            end
            if (!w_got && x4lwvalid) begin
                w_cnt++;
                if (w_cnt > v.w_dly) begin x4lwready = 1'b1; w_got = 1'b1; end
            end
        end
        chk("aw_w_handshake", 64'({aw_got, w_got}), 64'd3);
        @(negedge clk);
        x4lawready = 1'b0;  x4lwready = 1'b0;
        chk("write_valids_low", 64'({x4lawvalid, x4lwvalid}), 64'd0);
        n = 0;
        while (!done && n < 200) begin
            if (c > v.resp_dly) begin
                x4lbvalid = 1'b1;  x4lbresp = v.resp;
                if (x4lbready) done = 1'b1;
            end
            if (!done) begin @(negedge clk); c++; n++; end
        end
        chk("b_accepted", 64'(done), 64'd1);
        @(negedge clk);
        x4lbvalid = 1'b0;  x4lbresp = 2'b00;
    endtask

    // AXI4-Lite read slave: delayed AR ready, then a delayed R (or none).
    task automatic slave_read(input vec_t v);
        int n = 0, a_cnt = 0, c = 1;
        bit got = 1'b0, done = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            x4larready = 1'b0;
            if (x4larvalid) begin
                if (a_cnt == 0) chk("araddr", 64'(x4laraddr), 64'(v.addr));
                a_cnt++;
                if (a_cnt > v.a_dly) begin x4larready = 1'b1; got = 1'b1; end
            end
        end
        chk("ar_handshake", 64'(got), 64'd1);
        @(negedge clk);
        x4larready = 1'b0;
        chk("arvalid_drop", 64'(x4larvalid), 64'd0);
        if (v.resp_dly < NEVER) begin
            n = 0;
            while (!done && n < 200) begin
                if (c > v.resp_dly) begin
                    x4lrvalid = 1'b1;  x4lrdata = v.rdata;  x4lrresp = v.resp;
                    if (x4lrready) done = 1'b1;
                end
                if (!done) begin @(negedge clk); c++; n++; end
            end
            chk("r_accepted", 64'(done), 64'd1);
            @(negedge clk);
            x4lrvalid = 1'b0;  x4lrdata = 32'h0;  x4lrresp = 2'b00;
        end
    endtask

    task automatic do_xfer(input vec_t v);
        fork
            begin apb_begin(v); apb_finish(); end
            begin
                if (v.write) slave_write(v);
                else         slave_read(v);
            end
        join
    endtask

    vec_t vecs[11];
    vec_t v_never, v_next;

    initial begin
        // wr addr           wdata          strb a  w  resp  rsp    rdata         err chk exp_rdata      lat
        vecs[0]  = mkv(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0,  2'b00, 32'h0,         1'b0, 1'b0, 32'h0,         3);
        vecs[1]  = mkv(1'b1, 32'h1000_0044, 32'h0000_00AA, 4'h1, 4, 0, 0,  2'b00, 32'h0,         1'b0, 1'b0, 32'h0,         7);
        vecs[2]  = mkv(1'b0, 32'h2000_0000, 32'h0,         4'h0, 0, 0, 0,  2'b10, 32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678, 3);
        vecs[3]  = mkv(1'b0, 32'h2000_0004, 32'h0,         4'h0, 2, 0, 2,  2'b00, 32'hA5A5_5A5A, 1'b0, 1'b1, 32'hA5A5_5A5A, 7);
        vecs[4]  = mkv(1'b1, 32'h1000_0048, 32'h0BAD_CAFE, 4'hC, 0, 0, 0,  2'b11, 32'h0,         1'b1, 1'b0, 32'h0,         3);
        vecs[5]  = mkv(1'b1, 32'h1000_004C, 32'h1111_2222, 4'h3, 0, 0, 0,  2'b01, 32'h0,         1'b0, 1'b0, 32'h0,         3);
        vecs[6]  = mkv(1'b1, 32'h1000_0050, 32'h3333_4444, 4'hF, 1, 3, 0,  2'b00, 32'h0,         1'b0, 1'b0, 32'h0,         6);
        vecs[7]  = mkv(1'b0, 32'h2000_0008, 32'h0,         4'h0, 0, 0, 7,  2'b00, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 10);
        vecs[8]  = mkv(1'b0, 32'h2000_000C, 32'h0,         4'h0, 0, 0, 10, 2'b00, 32'hBAAD_BAAD, 1'b1, 1'b1, 32'h0,         10);
        vecs[9]  = mkv(1'b1, 32'h1000_0054, 32'h5555_6666, 4'hF, 0, 0, 8,  2'b00, 32'h0,         1'b1, 1'b1, 32'h0,         10);
        vecs[10] = mkv(1'b0, 32'h2000_0010, 32'h0,         4'h0, 0, 0, 0,  2'b00, 32'h1357_9BDF, 1'b0, 1'b1, 32'h1357_9BDF, 3);
        v_never  = mkv(1'b0, 32'h2000_0100, 32'h0,         4'h0, 0, 0, NEVER, 2'b00, 32'h0,      1'b1, 1'b1, 32'h0,         10);
        v_next   = mkv(1'b0, 32'h3000_0000, 32'h0,         4'h0, 0, 0, 0,  2'b00, 32'h0055_AA11, 1'b0, 1'b1, 32'h0055_AA11, -1);

        rstpp = 1'b1;
        spsel = 1'b0;  spenable = 1'b0;  spwrite = 1'b0;
        spaddr = 32'h0;  spwdata = 32'h0;  spstrb = 4'h0;
        x4lawready = 1'b0;  x4lwready = 1'b0;  x4larready = 1'b0;
        x4lbvalid = 1'b0;  x4lbresp = 2'b00;
        x4lrvalid = 1'b0;  x4lrresp = 2'b00;  x4lrdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({x4lawvalid, x4lwvalid, x4larvalid, x4lbready, x4lrready, spready, spslverr}), 64'd0);
        chk("reset_sprdata", 64'(sprdata), 64'd0);
        chk("reset_addr", 64'({x4lawaddr, x4laraddr}), 64'd0);
        chk("reset_wdata", 64'({x4lwdata, x4lwstrb}), 64'd0);
        rstpp = 1'b0;

        for (int i = 0; i < 11; i++) do_xfer(vecs[i]);

        // Reset pulsed while the write is stuck in WADDR.
        @(negedge clk);
        spsel = 1'b1;  spenable = 1'b0;  spwrite = 1'b1;  spaddr = 32'h1000_0060;  spwdata = 32'h7777_8888;
        @(negedge clk);
        spenable = 1'b1;
        @(negedge clk);
        chk("waddr_valids", 64'({x4lawvalid, x4lwvalid}), 64'd3);
        @(negedge clk);
        rstpp = 1'b1;
        #1;
        chk("async_reset_ctrl", 64'({x4lawvalid, x4lwvalid, x4larvalid, x4lbready, x4lrready, spready}), 64'd0);
        @(negedge clk);
        rstpp = 1'b0;  spsel = 1'b0;  spenable = 1'b0;
        do_xfer(vecs[0]);

        // Read times out with no response at all; next transfer must stall
        // until the late R is drained, and that data must never appear.
        do_xfer(v_never);
        apb_begin(v_next);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_no_ar", 64'({x4larvalid, spready}), 64'd0);
            chk("orphan_rready", 64'(x4lrready), 64'd1);
        end
        x4lrvalid = 1'b1;  x4lrdata = 32'hBAD0_BAD0;  x4lrresp = 2'b10;
        @(negedge clk);
        x4lrvalid = 1'b0;  x4lrdata = 32'h0;  x4lrresp = 2'b00;
        chk("orphan_drained", 64'(x4lrready), 64'd0);
        chk("orphan_data_dropped", 64'({spslverr, sprdata}), 64'h1_0000_0000);
        fork
            apb_finish();
            slave_read(v_next);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
